// File: rtl/nco_pkg.sv
// Shared definitions for the NCO receive side: default accumulator width,
// quadrant encoding of the square (sin,cos) pair and the meter state type.
package nco_pkg;

    localparam int REGISTER_WIDTH_DEFAULT = 64;

    // Quadrants in the order the NCO steps through them going forward.
    localparam logic [1:0] Q0 = 2'b11;
    localparam logic [1:0] Q1 = 2'b10;
    localparam logic [1:0] Q2 = 2'b00;
    localparam logic [1:0] Q3 = 2'b01;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } meter_state_t;

    function automatic logic [1:0] quad_next(input logic [1:0] q);
        logic [1:0] n;
        case (q)
            Q0:      n = Q1;
            Q1:      n = Q2;
            Q2:      n = Q3;
            default: n = Q0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input; clears to 0 on reset.
module sync_2ff
    import nco_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: non-blocking assignments make r_sync take the old r_meta, giving two stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/nco_freq_meter.sv
// Gated frequency meter: counts sine rising edges over 2^GATE_LOG2 clocks and scales
// the count to a phase increment. Define NCO_FREQ_METER_QUAD_CHECK_EN for quadrature checking.
module nco_freq_meter
    import nco_pkg::*;
#(
    parameter int REGISTER_WIDTH = REGISTER_WIDTH_DEFAULT,
    parameter int GATE_LOG2      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      sinewave_in,
    input  logic                      cosinewave_in,
    output logic [REGISTER_WIDTH-1:0] phase_increment_est,
    output logic [GATE_LOG2:0]        edge_count,
    output logic                      est_valid,
    output logic                      quad_error
);

    localparam int         EST_SHIFT    = REGISTER_WIDTH - GATE_LOG2;
    localparam logic [1:0] HOLDOFF_DONE = 2'd3;

    meter_state_t              r_state;
    logic [GATE_LOG2-1:0]      r_gate;
    logic [GATE_LOG2:0]        r_acc;
    logic                      r_sticky;
    logic [1:0]                r_holdoff;
    logic                      r_sin_prev;
    logic [REGISTER_WIDTH-1:0] r_est;
    logic [GATE_LOG2:0]        r_edge_count;
    logic                      r_est_valid;
    logic                      r_quad_error;

    logic                      w_sin_sync;
    logic                      w_detect_en;
    logic                      w_edge;
    logic                      w_gate_tc;
    logic                      w_quad_err;
    logic [GATE_LOG2:0]        w_count_final;
    logic [REGISTER_WIDTH-1:0] w_est_final;

    sync_2ff u_sync_sin (
        .clk   (clk),
        .reset (reset),
        .i_d   (sinewave_in),
        .o_q   (w_sin_sync)
    );

    // Holdoff keeps a high input from looking like an edge after reset or enable rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sin_prev <= 1'b0;
            r_holdoff  <= '0;
        end else begin
            r_sin_prev <= w_sin_sync;
            if (!enable) begin
                r_holdoff <= '0;
            end else if (r_holdoff != HOLDOFF_DONE) begin
                r_holdoff <= r_holdoff + 2'd1;
            end
        end
    end

    assign w_detect_en   = (r_holdoff == HOLDOFF_DONE);
    assign w_edge        = w_detect_en & w_sin_sync & ~r_sin_prev;
    assign w_gate_tc     = (r_gate == '1);
    assign w_count_final = r_acc + (GATE_LOG2+1)'(w_edge);
    assign w_est_final   = REGISTER_WIDTH'(w_count_final) << EST_SHIFT;

`ifdef NCO_FREQ_METER_QUAD_CHECK_EN
    logic       w_cos_sync;
    logic       r_cos_prev;
    logic [1:0] w_pair;
    logic [1:0] w_pair_prev;

    sync_2ff u_sync_cos (
        .clk   (clk),
        .reset (reset),
        .i_d   (cosinewave_in),
        .o_q   (w_cos_sync)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cos_prev <= 1'b0;
        end else begin
            r_cos_prev <= w_cos_sync;
        end
    end

    assign w_pair      = {w_sin_sync, w_cos_sync};
    assign w_pair_prev = {r_sin_prev, r_cos_prev};
    // Gate cycle 0 only takes the baseline sample of the new window.
    assign w_quad_err  = (r_state == ST_MEASURE) && w_detect_en && (r_gate != '0)
                       && (w_pair != w_pair_prev) && (w_pair != quad_next(w_pair_prev));
`else
    logic w_unused_cos;
    assign w_unused_cos = cosinewave_in;
    assign w_quad_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_gate       <= '0;
            r_acc        <= '0;
            r_sticky     <= 1'b0;
            r_est        <= '0;
            r_edge_count <= '0;
            r_est_valid  <= 1'b0;
            r_quad_error <= 1'b0;
        end else begin
            r_est_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_gate   <= '0;
                    r_acc    <= '0;
                    r_sticky <= 1'b0;
                    if (enable) begin
                        r_state <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (!enable) begin
                        // Aborted window: partial count is dropped, no strobe.
                        r_state  <= ST_IDLE;
                        r_gate   <= '0;
                        r_acc    <= '0;
                        r_sticky <= 1'b0;
                    end else begin
                        r_gate <= r_gate + GATE_LOG2'(1);
                        if (w_gate_tc) begin
                            r_edge_count <= w_count_final;
                            r_est        <= w_est_final;
                            r_quad_error <= r_sticky | w_quad_err;
                            r_est_valid  <= 1'b1;
                            r_acc        <= '0;
                            r_sticky     <= 1'b0;
                        end else begin
                            r_acc    <= w_count_final;
                            r_sticky <= r_sticky | w_quad_err;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign phase_increment_est = r_est;
    assign edge_count          = r_edge_count;
    assign est_valid           = r_est_valid;
    assign quad_error          = r_quad_error;

endmodule

// File: doc/nco_freq_meter.md
# nco_freq_meter

Gated frequency meter that reads back the 1-bit quadrature square waves produced by the NCO and estimates the phase increment that generated them. It counts rising edges of `sinewave_in` over a fixed window of 2^GATE_LOG2 clocks and scales the count into a REGISTER_WIDTH phase-increment word. It sits on the receive/loopback side of the NCO, used for self-test of the tuning path and for measuring external square-wave carriers.

## Interface
- `REGISTER_WIDTH`, 64: width of the phase-increment estimate; matches the NCO accumulator width.
- `GATE_LOG2`, 16: log2 of the gate window length in clocks. Legal range is 2 ≤ GATE_LOG2 < REGISTER_WIDTH.

- `clk`  in  1  single clock for the block.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  1 runs measurement windows; 0 idles the block.
- `sinewave_in`  in  1  square sine input, asynchronous to `clk`.
- `cosinewave_in`  in  1  square cosine input, asynchronous to `clk`.
- `phase_increment_est`  out  REGISTER_WIDTH  estimate, equal to `edge_count << (REGISTER_WIDTH-GATE_LOG2)`.
- `edge_count`  out  GATE_LOG2+1  rising edges counted in the last completed window.
- `est_valid`  out  1  one-cycle strobe; outputs were updated this cycle.
- `quad_error`  out  1  illegal quadrature transition seen in the last completed window.

## Operation
- Both inputs pass through 2-FF synchronizers. A registered previous-sample stage follows, so a rising edge is `sync & ~prev`.
- Edge detection is suppressed for the first 3 cycles after reset deasserts, and for the first 3 cycles after `enable` rises. This prevents a spurious edge when the input is already high.
- States:
  - IDLE: `enable`=0. Gate counter and edge accumulator are held at 0. Outputs hold their last values.
  - MEASURE: `enable`=1. Entered from IDLE on `enable`=1, starting with gate counter 0.
- In MEASURE, the gate counter counts 0 to 2^GATE_LOG2−1 and then wraps. Each detected edge increments the accumulator.
- At terminal count (gate = all ones):
  - `edge_count` is loaded with accumulator + (edge this cycle).
  - `quad_error` is loaded with the window's sticky error flag.
  - The accumulator and sticky flag are cleared.
- An edge in the terminal cycle belongs to the closing window. An edge in gate cycle 0 belongs to the new window.
- Maximum count is 2^(GATE_LOG2−1), reached by an input toggling every clock. The GATE_LOG2+1-bit accumulator cannot overflow.
- `enable` falling mid-window aborts the window: no strobe, accumulator is discarded, return to IDLE.
- Arithmetic is unsigned. `phase_increment_est` is a pure shift; the low REGISTER_WIDTH−GATE_LOG2 bits are always 0.

## Timing
- Reset values: `phase_increment_est`=0, `edge_count`=0, `est_valid`=0, `quad_error`=0. State is IDLE and all counters and synchronizers are 0.
- `est_valid` is high for exactly one cycle, the cycle after the terminal-count cycle. All outputs change on that same edge.
- Strobe period in steady MEASURE is exactly 2^GATE_LOG2 clocks.
- Input-to-detection latency is 3 clocks: 2 synchronizer stages plus the previous-sample stage.
- Reset asserted mid-window returns all registers to reset values immediately; no strobe is produced.

## Configuration
- `NCO_FREQ_METER_QUAD_CHECK_EN` defined:
  - The synchronized pair (sin,cos) is tracked through the NCO forward sequence 11→10→00→01→11.
  - Holding the same value is legal. Any backward step or two-bit change sets the sticky error flag.
  - The first sample of each window is a baseline only.
- Macro undefined:
  - `cosinewave_in` is ignored and `quad_error` is tied to 0.
  - The port list is unchanged.

## Structure
- Shared package `nco_pkg`:
  - the REGISTER_WIDTH default;
  - quadrant encoding constants Q0=2'b11, Q1=2'b10, Q2=2'b00, Q3=2'b01;
  - the IDLE/MEASURE state typedef.
- One sub-module, `sync_2ff`, instantiated once per input. It is reset-capable with a reset value of 0.

## Test plan
- Constant `sinewave_in`=0 with `enable`=1 and GATE_LOG2=8 → after 256 clocks, `est_valid` pulses once with `edge_count`=0 and `phase_increment_est`=0.
- Square wave with period 16 clocks, GATE_LOG2=8, REGISTER_WIDTH=64 → after the first full window, each strobe has `edge_count`=16 and `phase_increment_est`=0x1000_0000_0000_0000.
- Input toggling every clock → `edge_count`=128 with no overflow; `phase_increment_est`=0x8000_0000_0000_0000.
- Macro defined, sequence 11→10→11 injected mid-window → `quad_error`=1 at that window's strobe; a clean following window → `quad_error`=0.
- `reset` asserted at gate count 100 → all outputs 0 immediately, no `est_valid`; the next strobe comes 256+ clocks after reset release.
- `enable` dropped at gate count 200 → no strobe, outputs keep prior values; re-enable → the next strobe arrives exactly 256 clocks later.
